sram_responder: RTL

//  Memory-side responder for the core's req/addr_ok/data_ok SRAM-like bus (iram_* or dram_*).

---
 rtl/sram_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// sram_responder: SRAM-like bus responder; in-order data_ok LATENCY cycles after accept, up to DEPTH outstanding.
// Backpressure through addr_ok (count<DEPTH, no pop-bypass); define RESP_STALL_EN for LFSR-driven addr_ok stalls.
`ifndef XLEN
`define XLEN 32
`endif

module sram_responder #(
    parameter int AW      = 14,
    parameter int LATENCY = 1,
    parameter int DEPTH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 write,
    input  logic [`XLEN/8-1:0]   wstrb,
    input  logic [`XLEN-1:0]     addr,
    input  logic [`XLEN-1:0]     wdata,
    output logic                 addr_ok,
    output logic                 data_ok,
    output logic [`XLEN-1:0]     rdata
);
    localparam int XL = `XLEN;
    localparam int NB = XL / 8;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH4 = 4'(DEPTH);
    localparam logic [3:0] CNT0   = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "sram_responder: LATENCY must be 1..15");
    end
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $fatal(1, "sram_responder: DEPTH must be 1..8");
    end
    if (AW < 1 || AW + 2 >= XL) begin : g_bad_aw
        $fatal(1, "sram_responder: AW out of range for XLEN");
    end

    logic [XL-1:0] mem [2**AW];

    logic          ready;
    logic [3:0]    count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          vld   [DEPTH];
    logic          is_wr [DEPTH];
    logic [XL-1:0] snap  [DEPTH];
    logic [3:0]    cnt   [DEPTH];

    logic [AW-1:0] widx;
    logic          room;
    logic          push;
    logic          pop;
    logic          unused_addr;

    assign widx        = addr[AW+1:2];
    assign unused_addr = ^{addr[XL-1:AW+2], addr[1:0]};
    assign room        = (count < DEPTH4);

    // ready holds addr_ok low until the first edge after reset release.
`ifdef RESP_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    assign addr_ok = ready && room && !lfsr[0];
`else
    assign addr_ok = ready && room;
`endif

    assign push    = req && addr_ok;
    assign pop     = vld[head] && (cnt[head] == 4'd0);
    assign data_ok = pop;
    assign rdata   = (pop && !is_wr[head]) ? snap[head] : '0;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready <= 1'b0;
            count <= 4'd0;
            head  <= '0;
            tail  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                vld[i]   <= 1'b0;
                is_wr[i] <= 1'b0;
                snap[i]  <= '0;
                cnt[i]   <= 4'd0;
            end
        end else begin
            ready <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (vld[i] && cnt[i] != 4'd0) begin
                    cnt[i] <= cnt[i] - 4'd1;
                end
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= nxt(head);
            end
            // The tail slot is never valid while room exists, so the countdown loop cannot touch it.
            if (push) begin
                vld[tail]   <= 1'b1;
                is_wr[tail] <= write;
                snap[tail]  <= mem[widx];
                cnt[tail]   <= CNT0;
                tail        <= nxt(tail);
            end
            count <= count + {3'b000, push} - {3'b000, pop};
        end
    end

    // Array is deliberately left out of reset so accepted writes survive it.
    always_ff @(posedge clk) begin
        if (push && write) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) begin
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end
endmodule
